ppm_pingpong_frame_buffer: RTL
==============================

# ppm_pingpong_frame_buffer

Parametrised, double-banked frame buffer between the user byte interface and the PPM two-bit shift stage of the transmitter. The user loads a frame of 1..DEPTH words into one bank while the other bank streams its frame to the shift stage under a per-word send-done handshake. Each frame completion is reported with a delayed `frame_done` pulse. An optional CRC-8 trailer word can be compiled in.

## Interface
- `DW`, 8: data word width (must be 8 when `PPM_FBUF_CRC_EN` is defined).
- `DEPTH`, 16: words per bank; power of two, ≥2.
- `LW`, $clog2(DEPTH+1): width of the length field.
- `DONE_DLY`, 3: cycles from last send-done to `frame_done`; range 1..7.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `le` in 1: load-enable pulse; starts a frame load.
- `len` in LW: frame length, sampled with `le`; valid range 1..DEPTH.
- `din` in DW: user data word.
- `din_valid` in 1: `din` is valid this cycle while loading.
- `load_ready` out 1: at least one bank is empty and no load is in progress.
- `le_err` out 1: one-cycle pulse when `le` is rejected.
- `frame_ready` out 1: the read bank holds a full frame awaiting `start_trans`.
- `start_trans` in 1: begin transmitting the ready frame.
- `shift_data_send_done` in 1: shift stage has consumed the current `data_out`.
- `data_out` out DW: word presented to the shift stage.
- `shift_strobe` out 1: `data_out` is valid; high for the whole transmission.
- `frame_done` out 1: one-cycle pulse, `DONE_DLY` cycles after the last word's send-done.

## Operation
- **Banks:** two banks, B0 and B1, each DEPTH×DW, with a `full` flag and a stored length. `wr_bank` and `rd_bank` pointers both reset to B0.
- **Write FSM, W_IDLE → W_LOAD:**
  - `le` is accepted in W_IDLE only if `load_ready` is high and 1 ≤ `len` ≤ DEPTH. Otherwise the load is rejected, `le_err` pulses, and the state does not change.
  - In W_LOAD, each `din_valid` cycle writes `din` to `wr_bank[wr_idx]` and increments `wr_idx`.
  - When the len-th word is written, the bank is marked full, `wr_bank` toggles, and the FSM returns to W_IDLE.
  - `le` is ignored during W_LOAD.
- **Read FSM, R_IDLE → R_WAIT → R_SEND → R_IDLE:**
  - R_IDLE moves to R_WAIT when `rd_bank` is full. `frame_ready` = (state == R_WAIT).
  - R_WAIT moves to R_SEND on `start_trans`.
  - In R_SEND, `shift_strobe` = 1 and `data_out` = word[`rd_idx`].
  - Each `shift_data_send_done` increments `rd_idx`. The send-done for the last word clears the bank's `full` flag, toggles `rd_bank`, drops `shift_strobe`, and returns the FSM to R_IDLE.
- `data_out` is 0 outside R_SEND.
- **CRC:** when `PPM_FBUF_CRC_EN` is defined, the transmitted frame is len+1 words; see Configuration.
- **Widths:** `wr_idx` and `rd_idx` are $clog2(DEPTH)+1 bits wide, so no index wraps inside a frame.
- **Simultaneous events:**
  - If a bank is released in the same cycle that `le` arrives, `load_ready` still reflects the pre-release flags (registered), so the `le` may be rejected.
  - Loading B(n) and sending B(n^1) run fully concurrently.
  - Completing a load into `rd_bank` while the read FSM is in R_IDLE → R_WAIT on the next cycle.
- **Reset mid-operation:** both FSMs return to idle, both banks become empty, the pointers return to B0, the `frame_done` delay line is flushed, and no `frame_done` pulse is emitted.

## Timing
- Reset values: `load_ready` 1, `le_err` 0, `frame_ready` 0, `data_out` 0, `shift_strobe` 0, `frame_done` 0.
- **Load path:**
  - `le` accepted at edge t → W_LOAD from t+1; `load_ready` is low from t+1.
  - With `din_valid` held high, the last word is written at edge t+len.
  - The bank is full, and `load_ready` updates, at t+len+1.
- **Read path:**
  - `frame_ready` rises 1 cycle after the bank becomes full.
  - `start_trans` at edge s → `shift_strobe` = 1 and `data_out` = word 0 valid from s+1.
  - A send-done at edge d presents the next word from d+1.
- **Completion:**
  - The last send-done at edge d drops `shift_strobe` at d+1.
  - `frame_done` is high for exactly the cycle d+DONE_DLY.
- **Minimum gap:** with both banks full, the next `frame_ready` follows the previous `frame_done` source edge by 2 cycles.

## Configuration
- **`PPM_FBUF_CRC_EN` defined:**
  - A CRC-8 (polynomial 0x07, init 0x00, MSB-first, no reflection) is accumulated over the words as they are sent.
  - After the len-th send-done, R_SEND presents the CRC value as one extra word, held until its own send-done.
  - `frame_done` timing is referenced to the CRC word's send-done.
- **Undefined:** no CRC logic; the frame is exactly len words.

## Test plan
- **Basic frame:** reset; `le` with `len`=3 and `din` = 0xA1, 0xB2, 0xC3 with `din_valid` held high; `start_trans` after `frame_ready`; send-done every 4 cycles → `data_out` shows A1, B2, C3 in order; `shift_strobe` high throughout; `frame_done` pulses exactly 3 cycles after the third send-done.
- **Ping-pong:** load a 16-word frame into B0; start sending it; load 2 words into B1 during the send → B1 load completes with no stall; `frame_ready` rises 2 cycles after B0's last send-done; `load_ready` is 0 while both banks are full.
- **Illegal length:** `le` with `len`=0, then `len`=17 (DEPTH=16) → `le_err` pulses once for each; state unchanged; `load_ready` stays 1.
- **Backpressure and gaps:** `din_valid` gapped 1-in-3 and send-done delayed 10 cycles per word → the 5-word frame is sent intact and in order.
- **Reset mid-send:** assert `rst_n` low during word 2 of a 4-word frame → all outputs return to reset values; no `frame_done` pulse; the next frame transmits correctly from B0.
- **With `PPM_FBUF_CRC_EN`:** frame 0x01, 0x02 → third word is 0x1B; `frame_done` pulses 3 cycles after that word's send-done.

Source files
------------

// File: rtl/ppm_pingpong_frame_buffer.sv
// ppm_pingpong_frame_buffer: two-bank frame buffer, one bank loads while the other streams to the PPM shift stage.
// Define PPM_FBUF_CRC_EN to append a CRC-8 (poly 0x07) trailer word to each transmitted frame.
module ppm_pingpong_frame_buffer #(
  parameter int DW       = 8,
  parameter int DEPTH    = 16,
  parameter int LW       = $clog2(DEPTH + 1),
  parameter int DONE_DLY = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          le,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          load_ready,
  output logic          le_err,
  output logic          frame_ready,
  input  logic          start_trans,
  input  logic          shift_data_send_done,
  output logic [DW-1:0] data_out,
  output logic          shift_strobe,
  output logic          frame_done
);
  localparam int IW = $clog2(DEPTH) + 1;
  typedef enum logic {W_IDLE, W_LOAD} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_SEND} r_state_t;
  w_state_t            w_state, w_next;
  r_state_t            r_state, r_next;
  logic [DW-1:0]       mem [2][DEPTH];
  logic [LW-1:0]       blen [2];
  logic [1:0]          full;
  logic                wr_bank, rd_bank;
  logic [IW-1:0]       wr_idx, rd_idx, rd_last;
  logic [DONE_DLY-1:0] done_sr;
  logic                accept, wr_en, wr_last, start, send_last;
  logic [DW-1:0]       word;
  assign load_ready   = (w_state == W_IDLE) && !(&full);
  assign accept       = le && load_ready && len != '0 && len <= LW'(DEPTH);
  assign wr_en        = (w_state == W_LOAD) && din_valid;
  assign wr_last      = wr_en && (wr_idx + IW'(1) == IW'(blen[wr_bank]));
  assign start        = (r_state == R_WAIT) && start_trans;
  assign send_last    = shift_strobe && shift_data_send_done && rd_idx == rd_last;
  assign word         = mem[rd_bank][rd_idx[IW-2:0]];
  assign frame_ready  = r_state == R_WAIT;
  assign shift_strobe = r_state == R_SEND;
  assign frame_done   = done_sr[DONE_DLY-1];
`ifdef PPM_FBUF_CRC_EN
  logic [DW-1:0] crc;
  function automatic logic [DW-1:0] crc8(input logic [DW-1:0] c, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = {r[DW-2:0], 1'b0} ^ (r[DW-1] ? DW'(8'h07) : '0);
    return r;
  endfunction
  // the trailer sits one index past the last data word
  assign rd_last  = IW'(blen[rd_bank]);
  assign data_out = shift_strobe ? (rd_idx == rd_last ? crc : word) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc <= '0;
    else if (start) crc <= '0;
    else if (shift_strobe && shift_data_send_done && rd_idx != rd_last) crc <= crc8(crc, word);
  end
`else
  assign rd_last  = IW'(blen[rd_bank]) - IW'(1);
  assign data_out = shift_strobe ? word : '0;
`endif
  always_comb begin
    w_next = accept ? W_LOAD : wr_last ? W_IDLE : w_state;
    r_next = (r_state == R_IDLE && full[rd_bank]) ? R_WAIT : start ? R_SEND : send_last ? R_IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      rd_idx  <= '0;
      le_err  <= 1'b0;
      done_sr <= '0;
      blen[0] <= '0;
      blen[1] <= '0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      le_err  <= le && w_state == W_IDLE && !accept;
      full    <= (full | (wr_last ? 2'b01 << wr_bank : 2'b00)) & ~(send_last ? 2'b01 << rd_bank : 2'b00);
      done_sr <= DONE_DLY'({done_sr, send_last});
      if (accept) blen[wr_bank] <= len;
      wr_idx  <= accept ? '0 : wr_en ? wr_idx + IW'(1) : wr_idx;
      rd_idx  <= start ? '0 : (shift_strobe && shift_data_send_done) ? rd_idx + IW'(1) : rd_idx;
      if (wr_last) wr_bank <= ~wr_bank;
      if (send_last) rd_bank <= ~rd_bank;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_idx[IW-2:0]] <= din;
  end
endmodule
